// File: rtl/line_window_buffer_pkg.sv
// Shared types and constant helpers for the line window buffer.
package line_window_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Smallest r with 2**r >= value; 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned mem_count(input int unsigned n_lines);
    return n_lines - 1;
  endfunction

  // Write-select width, at least one bit even for a single memory.
  function automatic int unsigned sel_width(input int unsigned n_lines);
    int unsigned m;
    m = n_lines - 1;
    return (m < 2) ? 1 : clog2(m);
  endfunction

endpackage

// File: rtl/line_window_buffer_ram.sv
// Single-port read-first synchronous line memory; only the read register is reset.
module line_ram_rf #(
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned ADDR_BITS = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  (* ram_style = "block" *) logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  // Old content is returned on a simultaneous write (read-first).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (en) rdata <= mem[addr];
  end

endmodule

// File: rtl/line_window_buffer.sv
// Rotating multi-line buffer emitting an N_LINES-tall pixel column per input pixel.
module line_window_buffer
  import line_window_buffer_pkg::*;
#(
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned ADDR_BITS = 11,
  parameter int unsigned N_LINES   = 3,
  parameter int unsigned LINE_LEN  = 1920
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_valid,
  input  logic [DATA_W-1:0]           s_data,
  input  logic                        s_sof,
  input  logic                        s_eol,
  output logic                        m_valid,
  output logic [N_LINES*DATA_W-1:0]   m_data,
  output logic                        m_eol,
  output logic [ADDR_BITS-1:0]        m_col,
  output logic                        err_len
);

  localparam int unsigned M     = mem_count(N_LINES);
  localparam int unsigned SEL_W = sel_width(N_LINES);
  localparam int unsigned CNT_W = clog2(M + 1);

  localparam logic [ADDR_BITS-1:0] LAST_COL = ADDR_BITS'(LINE_LEN - 1);
  localparam logic [SEL_W-1:0]     LAST_SEL = SEL_W'(M - 1);
  localparam logic [CNT_W-1:0]     FULL_CNT = CNT_W'(M);

  state_t               state, state_nxt;
  logic [ADDR_BITS-1:0] col, col_nxt, col_eff;
  logic [SEL_W-1:0]     wr_sel, sel_nxt, sel_eff, sel_q;
  logic [CNT_W-1:0]     line_cnt, cnt_nxt, cnt_eff;
  logic                 err_nxt, valid_nxt, accept, close;
  logic [DATA_W-1:0]    tap0_q;
  logic [DATA_W-1:0]    ram_rdata [M];
  int                   tap_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and bookkeeping; a frame start overrides the running counters first.
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    sel_nxt   = wr_sel;
    cnt_nxt   = line_cnt;
    err_nxt   = err_len;
    valid_nxt = 1'b0;
    close     = 1'b0;
    col_eff   = col;
    sel_eff   = wr_sel;
    cnt_eff   = line_cnt;
    accept    = s_valid && ((state != ST_IDLE) || s_sof);

    if (s_sof) begin
      col_eff = '0;
      sel_eff = '0;
      cnt_eff = '0;
    end

    if (accept) begin
      close     = s_eol || (col_eff == LAST_COL);
      valid_nxt = (state == ST_RUN) && !s_sof;
      err_nxt   = (s_sof ? 1'b0 : err_len) | (s_eol != (col_eff == LAST_COL));
      if (close) begin
        col_nxt = '0;
        sel_nxt = (sel_eff == LAST_SEL) ? '0 : sel_eff + SEL_W'(1);
        cnt_nxt = (cnt_eff == FULL_CNT) ? cnt_eff : cnt_eff + CNT_W'(1);
      end else begin
        col_nxt = col_eff + ADDR_BITS'(1);
        sel_nxt = sel_eff;
        cnt_nxt = cnt_eff;
      end
      state_nxt = (cnt_nxt == FULL_CNT) ? ST_RUN : ST_FILL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col      <= '0;
      wr_sel   <= '0;
      line_cnt <= '0;
      err_len  <= 1'b0;
      m_valid  <= 1'b0;
      m_eol    <= 1'b0;
      m_col    <= '0;
      tap0_q   <= '0;
      sel_q    <= '0;
    end else begin
      col      <= col_nxt;
      wr_sel   <= sel_nxt;
      line_cnt <= cnt_nxt;
      err_len  <= err_nxt;
      m_valid  <= valid_nxt;
      if (accept) begin
        m_eol  <= s_eol;
        m_col  <= col_eff;
        tap0_q <= s_data;
        sel_q  <= sel_eff;
      end
    end
  end

  for (genvar g = 0; g < M; g++) begin : g_mem
    line_ram_rf #(
      .DATA_W   (DATA_W),
      .ADDR_BITS(ADDR_BITS)
    ) u_ram (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (accept),
      .we   (sel_eff == SEL_W'(g)),
      .addr (col_eff),
      .wdata(s_data),
      .rdata(ram_rdata[g])
    );
  end

  // Tap k comes from memory (sel_q - k) mod M, selected among already-registered read data.
  always_comb begin
    tap_idx = 0;
    m_data  = '0;
    m_data[DATA_W-1:0] = tap0_q;
    for (int k = 1; k <= int'(M); k++) begin
      tap_idx = int'(sel_q) + int'(M) - k;
      if (tap_idx >= int'(M)) tap_idx = tap_idx - int'(M);
      m_data[k*DATA_W +: DATA_W] = ram_rdata[SEL_W'(tap_idx)];
    end
  end

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed self-checking bench: 3-line column, 4-pixel lines, pixel = line*16 + col.
module tb_line_window_buffer;

  localparam int unsigned DATA_W    = 24;
  localparam int unsigned ADDR_BITS = 11;
  localparam int unsigned N_LINES   = 3;
  localparam int unsigned LINE_LEN  = 4;

  logic                      clk;
  logic                      rst_n;
  logic                      s_valid;
  logic [DATA_W-1:0]         s_data;
  logic                      s_sof;
  logic                      s_eol;
  logic                      m_valid;
  logic [N_LINES*DATA_W-1:0] m_data;
  logic                      m_eol;
  logic [ADDR_BITS-1:0]      m_col;
  logic                      err_len;

  int n_pass;
  int n_total;

  line_window_buffer #(
    .DATA_W   (DATA_W),
    .ADDR_BITS(ADDR_BITS),
    .N_LINES  (N_LINES),
    .LINE_LEN (LINE_LEN)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_valid(s_valid),
    .s_data (s_data),
    .s_sof  (s_sof),
    .s_eol  (s_eol),
    .m_valid(m_valid),
    .m_data (m_data),
    .m_eol  (m_eol),
    .m_col  (m_col),
    .err_len(err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  function automatic logic [DATA_W-1:0] pv(input int l, input int c);
    return 24'(l * 16 + c);
  endfunction

  // Expected column {tap2, tap1, tap0} for frame line l >= 2.
  function automatic logic [N_LINES*DATA_W-1:0] exp_col(input int l, input int c);
    return {pv(l - 2, c), pv(l - 1, c), pv(l, c)};
  endfunction

  // Drive one pixel on the falling edge, optionally preceded by a ~30% bubble; returns #1 after the capture edge.
  task automatic px(input logic [DATA_W-1:0] d, input logic sof, input logic eol, input bit bubble);
    if (bubble && ($urandom_range(0, 99) < 30)) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_data  = 24'($urandom);
      s_sof   = 1'($urandom);
      s_eol   = 1'($urandom);
      @(posedge clk);
    end
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    s_eol   = eol;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s_valid = 1'($urandom);
      s_sof   = 1'($urandom);
      s_eol   = 1'($urandom);
      s_data  = 24'($urandom);
      @(posedge clk);
      #1;
      n_total++;
      if ({m_valid, m_eol, err_len} !== 3'b000 || m_col !== '0 || m_data !== '0) begin
        $display("FAIL reset_hold cyc%0d: got v=%b e=%b err=%b col=%0d data=%h, want all zero",
                 i, m_valid, m_eol, err_len, m_col, m_data);
      end else n_pass++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
    rst_n   = 1'b1;
    for (int c = 0; c < 4; c++) begin
      px(pv(9, c), 1'b0, c == 3, 1'b0);
      n_total++;
      if (m_valid !== 1'b0) $display("FAIL no_sof_ignored c%0d: got m_valid=%b want 0", c, m_valid);
      else n_pass++;
    end
  endtask

  task automatic test_fill();
    for (int l = 0; l < 3; l++) begin
      for (int c = 0; c < 4; c++) begin
        px(pv(l, c), (l == 0) && (c == 0), c == 3, 1'b0);
        n_total++;
        if (l < 2) begin
          if (m_valid !== 1'b0) $display("FAIL fill_quiet l%0d c%0d: got m_valid=%b want 0", l, c, m_valid);
          else n_pass++;
        end else begin
          if (m_valid !== 1'b1 || m_col !== 11'(c) || m_data !== exp_col(l, c))
            $display("FAIL fill_data l%0d c%0d: got v=%b col=%0d data=%h want v=1 col=%0d data=%h",
                     l, c, m_valid, m_col, m_data, c, exp_col(l, c));
          else n_pass++;
        end
        if (l == 2 && c == 0) begin
          n_total++;
          if (m_data !== 72'h000000_000010_000020 || m_col !== 11'd0)
            $display("FAIL fill_first_col: got col=%0d data=%h want col=0 data=000000000010000020", m_col, m_data);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_rotation();
    for (int l = 3; l < 5; l++) begin
      for (int c = 0; c < 4; c++) begin
        px(pv(l, c), 1'b0, c == 3, 1'b0);
        n_total++;
        if (m_valid !== 1'b1 || m_col !== 11'(c) || m_data !== exp_col(l, c) || m_eol !== (c == 3))
          $display("FAIL rot_data l%0d c%0d: got v=%b col=%0d eol=%b data=%h want v=1 col=%0d data=%h",
                   l, c, m_valid, m_col, m_eol, m_data, c, exp_col(l, c));
        else n_pass++;
        if (l == 3 && c == 2) begin
          n_total++;
          if (m_data !== 72'h000012_000022_000032)
            $display("FAIL rot_l3c2: got %h want 000012000022000032", m_data);
          else n_pass++;
        end
        if (l == 4 && c == 3) begin
          n_total++;
          if (m_data !== 72'h000023_000033_000043 || m_eol !== 1'b1)
            $display("FAIL rot_l4c3: got data=%h eol=%b want 000023000033000043 eol=1", m_data, m_eol);
          else n_pass++;
        end
      end
    end
    n_total++;
    if (err_len !== 1'b0) $display("FAIL rot_no_err: got err_len=%b want 0", err_len);
    else n_pass++;
  endtask

  task automatic test_length_error();
    for (int c = 0; c < 3; c++) px(pv(5, c), 1'b0, c == 2, 1'b0);
    n_total++;
    if (err_len !== 1'b1 || m_eol !== 1'b1 || m_col !== 11'd2)
      $display("FAIL short_eol: got err=%b eol=%b col=%0d want err=1 eol=1 col=2", err_len, m_eol, m_col);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      px(pv(6, i), 1'b0, 1'b0, 1'b0);
      n_total++;
      if (m_valid !== 1'b1 || m_col !== 11'(i % 4) || err_len !== 1'b1)
        $display("FAIL forced_close i%0d: got v=%b col=%0d err=%b want v=1 col=%0d err=1",
                 i, m_valid, m_col, err_len, i % 4);
      else n_pass++;
    end
    for (int c = 1; c < 4; c++) begin
      px(pv(7, c), 1'b0, c == 3, 1'b0);
      n_total++;
      if (m_col !== 11'(c) || err_len !== 1'b1)
        $display("FAIL err_sticky c%0d: got col=%0d err=%b want col=%0d err=1", c, m_col, err_len, c);
      else n_pass++;
    end
  endtask

  task automatic test_restart();
    px(pv(8, 0), 1'b0, 1'b0, 1'b0);
    n_total++;
    if (m_valid !== 1'b1 || m_col !== 11'd0)
      $display("FAIL pre_restart: got v=%b col=%0d want v=1 col=0", m_valid, m_col);
    else n_pass++;
    px(pv(0, 0), 1'b1, 1'b0, 1'b0);
    n_total++;
    if (m_valid !== 1'b0 || err_len !== 1'b0)
      $display("FAIL restart_sof: got v=%b err=%b want v=0 err=0", m_valid, err_len);
    else n_pass++;
    for (int l = 0; l < 3; l++) begin
      for (int c = (l == 0) ? 1 : 0; c < 4; c++) begin
        px(pv(l, c), 1'b0, c == 3, 1'b0);
        n_total++;
        if (l < 2) begin
          if (m_valid !== 1'b0) $display("FAIL restart_quiet l%0d c%0d: got m_valid=%b want 0", l, c, m_valid);
          else n_pass++;
        end else begin
          if (m_valid !== 1'b1 || m_col !== 11'(c) || m_data !== exp_col(l, c))
            $display("FAIL restart_data l%0d c%0d: got v=%b col=%0d data=%h want v=1 col=%0d data=%h",
                     l, c, m_valid, m_col, m_data, c, exp_col(l, c));
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_gaps();
    for (int l = 0; l < 5; l++) begin
      for (int c = 0; c < 4; c++) begin
        px(pv(l, c), (l == 0) && (c == 0), c == 3, 1'b1);
        n_total++;
        if (l < 2) begin
          if (m_valid !== 1'b0) $display("FAIL gaps_quiet l%0d c%0d: got m_valid=%b want 0", l, c, m_valid);
          else n_pass++;
        end else begin
          if (m_valid !== 1'b1 || m_col !== 11'(c) || m_data !== exp_col(l, c) || m_eol !== (c == 3))
            $display("FAIL gaps_data l%0d c%0d: got v=%b col=%0d eol=%b data=%h want v=1 col=%0d data=%h",
                     l, c, m_valid, m_col, m_eol, m_data, c, exp_col(l, c));
          else n_pass++;
        end
      end
    end
    n_total++;
    if (err_len !== 1'b0) $display("FAIL gaps_no_err: got err_len=%b want 0", err_len);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    px(pv(5, 0), 1'b0, 1'b0, 1'b0);
    px(pv(5, 1), 1'b0, 1'b0, 1'b0);
    n_total++;
    if (m_valid !== 1'b1 || m_col !== 11'd1)
      $display("FAIL pre_async: got v=%b col=%0d want v=1 col=1", m_valid, m_col);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({m_valid, m_eol, err_len} !== 3'b000 || m_col !== '0 || m_data !== '0)
      $display("FAIL async_reset: got v=%b e=%b err=%b col=%0d data=%h want all zero",
               m_valid, m_eol, err_len, m_col, m_data);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 2; c < 4; c++) begin
      px(pv(5, c), 1'b0, c == 3, 1'b0);
      n_total++;
      if (m_valid !== 1'b0) $display("FAIL post_async_idle c%0d: got m_valid=%b want 0", c, m_valid);
      else n_pass++;
    end
    for (int l = 0; l < 3; l++) begin
      for (int c = 0; c < 4; c++) begin
        px(pv(l, c), (l == 0) && (c == 0), c == 3, 1'b0);
        n_total++;
        if (l < 2) begin
          if (m_valid !== 1'b0) $display("FAIL post_async_fill l%0d c%0d: got m_valid=%b want 0", l, c, m_valid);
          else n_pass++;
        end else begin
          if (m_valid !== 1'b1 || m_col !== 11'(c) || m_data !== exp_col(l, c))
            $display("FAIL post_async_data l%0d c%0d: got v=%b col=%0d data=%h want v=1 col=%0d data=%h",
                     l, c, m_valid, m_col, m_data, c, exp_col(l, c));
          else n_pass++;
        end
      end
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
    test_reset();
    test_fill();
    test_rotation();
    test_length_error();
    test_restart();
    test_gaps();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
